// File: rtl/comparador_pkg.sv
// Shared mode type and constants for the multi-channel compare unit.
package comparador_pkg;

    typedef logic [1:0] modo_t;

    localparam modo_t MODO_OFF = 2'b00;
    localparam modo_t MODO_EQ  = 2'b01;
    localparam modo_t MODO_GE  = 2'b10;
    localparam modo_t MODO_UNA = 2'b11;

endpackage

// File: rtl/comparador_canal.sv
// One compare channel: value/mode registers, match, pulse and sticky flag.
module comparador_canal
    import comparador_pkg::*;
#(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] contador,
    input  logic             wr_sel,
    input  logic [ANCHO-1:0] wr_valor,
    input  modo_t            wr_modo,
    input  logic             clr,
    output logic             coincide,
    output logic             pulso,
    output logic             bandera
);

    logic [ANCHO-1:0] valor_q, valor_d;
    modo_t            modo_q, modo_d;
    logic             coincide_q, coincide_d;
    logic             pulso_q, pulso_d;
    logic             bandera_q, bandera_d;
    logic             m;

    always_comb begin
        m = 1'b0;
        case (modo_q)
            MODO_EQ, MODO_UNA: m = (contador == valor_q);
            MODO_GE:           m = (contador >= valor_q);
            default:           m = 1'b0;
        endcase
    end

    // A write restarts the channel: the old setting can neither match nor pulse.
    always_comb begin
        valor_d    = valor_q;
        modo_d     = modo_q;
        coincide_d = m & ~wr_sel;
        pulso_d    = m & ~coincide_q & ~wr_sel;
        bandera_d  = pulso_d | (bandera_q & ~clr);
        if (wr_sel) begin
            valor_d = wr_valor;
            modo_d  = wr_modo;
        end else if (pulso_d && modo_q == MODO_UNA) begin
            modo_d = MODO_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valor_q    <= '0;
            modo_q     <= MODO_OFF;
            coincide_q <= 1'b0;
            pulso_q    <= 1'b0;
            bandera_q  <= 1'b0;
        end else begin
            valor_q    <= valor_d;
            modo_q     <= modo_d;
            coincide_q <= coincide_d;
            pulso_q    <= pulso_d;
            bandera_q  <= bandera_d;
        end
    end

    assign coincide = coincide_q;
    assign pulso    = pulso_q;
    assign bandera  = bandera_q;

endmodule

// File: rtl/comparador_multicanal.sv
// Multi-channel compare unit: write decode, channel array and interrupt line.
module comparador_multicanal
    import comparador_pkg::*;
#(
    parameter  int ANCHO   = 16,
    parameter  int CANALES = 4,
    localparam int IDX_W   = (CANALES > 1) ? $clog2(CANALES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANCHO-1:0]   contador,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_canal,
    input  logic [ANCHO-1:0]   wr_valor,
    input  logic [1:0]         wr_modo,
    input  logic [CANALES-1:0] clr_bandera,
    output logic [CANALES-1:0] coincide,
    output logic [CANALES-1:0] pulso,
    output logic [CANALES-1:0] bandera,
    output logic               irq
);

    logic [CANALES-1:0] wr_sel;
    logic               irq_q, irq_d;

    // Out-of-range channel numbers decode to no channel at all.
    always_comb begin
        for (int i = 0; i < CANALES; i++) begin
            wr_sel[i] = wr_en && (wr_canal == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < CANALES; g++) begin : g_canal
        comparador_canal #(
            .ANCHO(ANCHO)
        ) u_canal (
            .clk      (clk),
            .rst      (rst),
            .contador (contador),
            .wr_sel   (wr_sel[g]),
            .wr_valor (wr_valor),
            .wr_modo  (modo_t'(wr_modo)),
            .clr      (clr_bandera[g]),
            .coincide (coincide[g]),
            .pulso    (pulso[g]),
            .bandera  (bandera[g])
        );
    end

    always_comb begin
        irq_d = |bandera;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
